mem_arbiter: RTL and testbench

Shares the single external memory port between the execute unit's three CPU access types (instruction fetch, data read, data write) and one DMA requester. It sits between the execute unit's fetch and load/store handshakes and the memory/IO bus. It grants one transaction at a time, registers the address and data onto the bus, and waits for the bus acknowledge. It then returns a one-cycle done pulse with the read data. A watchdog aborts transactions whose acknowledge never arrives.

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Execute-unit fetch/load-store handshakes, DMA requester and external memory bus
// seen by mem_arbiter. The arbiter connects through the master modport.
interface mem_arbiter_if #(
  parameter int RV = 32,
  parameter int VA = RV
);
  localparam int AW = VA - RV/16;
  localparam int MW = RV/8;

  logic          c_ifetch;
  logic [VA-1:1] c_pc;
  logic [1:0]    c_rstrobe;
  logic [MW-1:0] c_wmask;
  logic [AW-1:0] c_addr;
  logic [RV-1:0] c_wdata;
  logic          c_io;
  logic          c_idone, c_rdone, c_wdone;
  logic [RV-1:0] c_rdata;

  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [RV-1:0] d_wdata;
  logic [MW-1:0] d_wmask;
  logic          d_done;
  logic [RV-1:0] d_rdata;

  logic          m_req, m_we, m_io;
  logic [AW-1:0] m_addr;
  logic [RV-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  logic          m_ack;
  logic [RV-1:0] m_rdata;
  logic          bus_err;

  modport master (
    input  c_ifetch, c_pc, c_rstrobe, c_wmask, c_addr, c_wdata, c_io,
    output c_idone, c_rdone, c_wdone, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_done, d_rdata,
    output m_req, m_we, m_io, m_addr, m_wdata, m_wmask,
    input  m_ack, m_rdata,
    output bus_err
  );

  modport slave (
    output c_ifetch, c_pc, c_rstrobe, c_wmask, c_addr, c_wdata, c_io,
    input  c_idone, c_rdone, c_wdone, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_done, d_rdata,
    input  m_req, m_we, m_io, m_addr, m_wdata, m_wmask,
    output m_ack, m_rdata,
    input  bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU fetch/read/write vs DMA, round-robin between
// CPU and DMA, one transaction in flight, watchdog abort on missing ack.
module mem_arbiter #(
  parameter int RV      = 32,
  parameter int VA      = RV,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int AW = VA - RV/16;
  localparam int MW = RV/8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OWN_FETCH, OWN_READ, OWN_WRITE, OWN_DMA} owner_t;

  typedef struct packed {
    logic          we;
    logic          io;
    logic [AW-1:0] addr;
    logic [RV-1:0] wdata;
    logic [MW-1:0] wmask;
  } bus_fields_t;

  state_t        state, state_nxt;
  owner_t        owner, win;
  bus_fields_t   fields, win_fields;
  logic          last_dma;
  logic [7:0]    cnt;
  logic          err;
  logic [RV-1:0] c_rdata_q, d_rdata_q;
  logic          cpu_pend, dma_pend, pick_dma;
  logic          grant, fin_ack, fin_to;

  assign cpu_pend = bus.c_ifetch | (|bus.c_rstrobe) | (|bus.c_wmask);
  assign dma_pend = bus.d_req;
  // DMA wins only when alone or when the CPU owned the previous transaction.
  assign pick_dma = dma_pend & (~cpu_pend | ~last_dma);

  always_comb begin
    win        = OWN_FETCH;
    win_fields = '0;
    if (pick_dma) begin
      win              = OWN_DMA;
      win_fields.we    = bus.d_we;
      win_fields.addr  = bus.d_addr;
      win_fields.wdata = bus.d_wdata;
      win_fields.wmask = bus.d_we ? bus.d_wmask : '0;
    end else if (|bus.c_wmask) begin
      win              = OWN_WRITE;
      win_fields.we    = 1'b1;
      win_fields.io    = bus.c_io;
      win_fields.addr  = bus.c_addr;
      win_fields.wdata = bus.c_wdata;
      win_fields.wmask = bus.c_wmask;
    end else if (|bus.c_rstrobe) begin
      win              = OWN_READ;
      win_fields.io    = bus.c_io;
      win_fields.addr  = bus.c_addr;
    end else begin
      win_fields.addr  = bus.c_pc[VA-1:RV/16];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fin_ack   = 1'b0;
    fin_to    = 1'b0;
    case (state)
      IDLE: if (cpu_pend | dma_pend) begin
        grant     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (bus.m_ack) begin
        fin_ack   = 1'b1;
        state_nxt = DONE;
      end else if (cnt == CNT_LAST) begin
        fin_to    = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fields    <= '0;
      owner     <= OWN_FETCH;
      last_dma  <= 1'b1;
      cnt       <= '0;
      err       <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant) begin
        fields <= win_fields;
        owner  <= win;
        cnt    <= '0;
        err    <= 1'b0;
      end
      if (state == BUSY) cnt <= cnt + 8'd1;
      if (fin_ack || fin_to) begin
        if (owner == OWN_DMA) d_rdata_q <= fin_ack ? bus.m_rdata : '1;
        else                  c_rdata_q <= fin_ack ? bus.m_rdata : '1;
      end
      if (fin_to) err <= 1'b1;
      if (state == DONE) last_dma <= (owner == OWN_DMA);
    end
  end

  assign bus.m_req   = (state == BUSY);
  assign bus.m_we    = fields.we;
  assign bus.m_io    = fields.io;
  assign bus.m_addr  = fields.addr;
  assign bus.m_wdata = fields.wdata;
  assign bus.m_wmask = fields.wmask;

  assign bus.c_idone = (state == DONE) && (owner == OWN_FETCH);
  assign bus.c_rdone = (state == DONE) && (owner == OWN_READ);
  assign bus.c_wdone = (state == DONE) && (owner == OWN_WRITE);
  assign bus.d_done  = (state == DONE) && (owner == OWN_DMA);
  assign bus.bus_err = (state == DONE) && err;
  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  // Fetch addresses are halfword-granular; the sub-word bits never reach the bus.
  if (RV/16 > 1) begin : g_pc_low
    logic unused_pc;
    assign unused_pc = ^bus.c_pc[RV/16-1:1];
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level
// model of the arbitration rules (RV=32 with TIMEOUT=4, and an RV=16 build).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.RV(32), .VA(32)) bi ();
  mem_arbiter_if #(.RV(16), .VA(16)) bh ();

  mem_arbiter #(.RV(32), .VA(32), .TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bi.master));
  mem_arbiter #(.RV(16), .VA(16))            dut16 (.clk(clk), .reset(reset), .bus(bh.master));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear();
    bi.c_ifetch = 0; bi.c_pc = '0; bi.c_rstrobe = 0; bi.c_wmask = 0; bi.c_addr = '0;
    bi.c_wdata = '0; bi.c_io = 0; bi.d_req = 0; bi.d_we = 0; bi.d_addr = '0;
    bi.d_wdata = '0; bi.d_wmask = '0; bi.m_ack = 0; bi.m_rdata = '0;
    bh.c_ifetch = 0; bh.c_pc = '0; bh.c_rstrobe = 0; bh.c_wmask = 0; bh.c_addr = '0;
    bh.c_wdata = '0; bh.c_io = 0; bh.d_req = 0; bh.d_we = 0; bh.d_addr = '0;
    bh.d_wdata = '0; bh.d_wmask = '0; bh.m_ack = 0; bh.m_rdata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // random-phase model state
  bit pf, pr, pw, pd, in_txn, to, last_dma_m, exp_we;
  int own, idx, ack_at, stall, hi;
  logic [31:0] pc_b, mrd, ea, ewm;
  bit ewe, eio;
  logic [3:0] dn, exp_dn;

  initial begin
    clear();
    reset = 0;
    step(); step();
    chk("rst_mreq", bi.m_req, 0);
    chk("rst_dones", {bi.c_idone, bi.c_rdone, bi.c_wdone, bi.d_done, bi.bus_err}, 0);
    chk("rst_we_wmask", {bi.m_we, bi.m_wmask}, 0);
    chk("rst_rdata", {bi.c_rdata, bi.d_rdata}, 0);
    chk("rst_maddr", bi.m_addr, 0);
    chk("rst16_mreq", bh.m_req, 0);
    reset = 1;

    // single fetch, byte PC 0x102
    pc_b = 32'h102; bi.c_pc = pc_b[31:1]; bi.c_ifetch = 1; bi.m_rdata = 32'hDEADBEEF;
    step();
    chk("f_mreq", bi.m_req, 1);
    chk("f_maddr", bi.m_addr, 32'h40);
    chk("f_we_wmask", {bi.m_we, bi.m_wmask}, 0);
    bi.m_ack = 1;
    step();
    chk("f_idone", bi.c_idone, 1);
    chk("f_rdata", bi.c_rdata, 32'hDEADBEEF);
    chk("f_mreq_drop", bi.m_req, 0);
    bi.m_ack = 0; bi.c_ifetch = 0;
    step();
    chk("f_idone_once", bi.c_idone, 0);

    // write and fetch together: write first
    bi.c_wmask = 4'b0010; bi.c_wdata = 32'h11223344; bi.c_addr = 30'h123; bi.c_io = 1;
    pc_b = 32'h200; bi.c_pc = pc_b[31:1]; bi.c_ifetch = 1;
    step();
    chk("wf_we", bi.m_we, 1);
    chk("wf_wmask", bi.m_wmask, 4'b0010);
    chk("wf_io", bi.m_io, 1);
    chk("wf_addr", bi.m_addr, 30'h123);
    chk("wf_wdata", bi.m_wdata, 32'h11223344);
    bi.m_ack = 1;
    step();
    chk("wf_wdone", {bi.c_wdone, bi.c_idone}, 2'b10);
    bi.m_ack = 0; bi.c_wmask = 0;
    step(); step();
    chk("wf_fetch_grant", {bi.m_req, bi.m_we, bi.m_io}, 3'b100);
    chk("wf_fetch_addr", bi.m_addr, 32'h80);
    bi.m_ack = 1;
    step();
    chk("wf_idone", bi.c_idone, 1);
    bi.m_ack = 0; bi.c_ifetch = 0;
    step();

    // read vs DMA back-to-back after reset: CPU, DMA, CPU, DMA
    reset = 0; step(); reset = 1;
    bi.c_rstrobe = 2'b01; bi.c_addr = 30'h0AA; bi.c_io = 0;
    bi.d_req = 1; bi.d_we = 0; bi.d_addr = 30'h155;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rr_mreq", bi.m_req, 1);
      chk("rr_owner_addr", bi.m_addr, (i % 2) ? 30'h155 : 30'h0AA);
      bi.m_rdata = 32'h1000 + i; bi.m_ack = 1;
      step();
      chk("rr_dones", {bi.d_done, bi.c_rdone}, (i % 2) ? 2'b10 : 2'b01);
      chk("rr_rdata", (i % 2) ? bi.d_rdata : bi.c_rdata, 32'h1000 + i);
      bi.m_ack = 0;
      if (i == 3) begin bi.c_rstrobe = 0; bi.d_req = 0; end
      step(); step();
    end

    // watchdog abort with TIMEOUT=4
    bi.c_rstrobe = 2'b10; bi.c_addr = 30'h5;
    step();
    hi = 0;
    for (int k = 0; k < 10 && bi.m_req; k++) begin hi++; step(); end
    chk("to_mreq_len", hi, 4);
    chk("to_rdone", bi.c_rdone, 1);
    chk("to_err", bi.bus_err, 1);
    chk("to_rdata", bi.c_rdata, 32'hFFFFFFFF);
    bi.c_rstrobe = 0;
    step();
    chk("to_err_once", bi.bus_err, 0);

    // reset during BUSY
    pc_b = 32'h0; bi.c_pc = pc_b[31:1]; bi.c_ifetch = 1;
    step();
    chk("rb_mreq", bi.m_req, 1);
    reset = 0;
    step();
    chk("rb_mreq_drop", bi.m_req, 0);
    chk("rb_nodone", {bi.c_idone, bi.c_rdone, bi.c_wdone, bi.d_done, bi.bus_err}, 0);
    bi.c_ifetch = 0; bi.m_ack = 1;
    step();
    reset = 1;
    step();
    chk("rb_late_ack", {bi.m_req, bi.c_idone, bi.c_rdone, bi.c_wdone, bi.d_done}, 0);
    bi.m_ack = 0; pc_b = 32'h400; bi.c_pc = pc_b[31:1]; bi.c_ifetch = 1;
    step();
    chk("rb_regrant", {bi.m_req, bi.m_addr}, {1'b1, 30'h100});
    bi.m_ack = 1;
    step();
    chk("rb_idone", bi.c_idone, 1);
    bi.m_ack = 0; bi.c_ifetch = 0;
    step();

    // RV=16 DMA write
    bh.d_req = 1; bh.d_we = 1; bh.d_wmask = 2'b01; bh.d_addr = 15'h1234; bh.d_wdata = 16'hABCD;
    step();
    chk("h_mreq_we", {bh.m_req, bh.m_we}, 2'b11);
    chk("h_wmask", bh.m_wmask, 2'b01);
    chk("h_addr_wdata", {bh.m_addr, bh.m_wdata}, {15'h1234, 16'hABCD});
    bh.m_ack = 1;
    step();
    chk("h_ddone", bh.d_done, 1);
    bh.d_req = 0; bh.m_ack = 0;
    step();
    chk("h_ddone_once", bh.d_done, 0);

    // randomized traffic against the transaction-level model
    reset = 0; step(); reset = 1;
    last_dma_m = 1; pf = 0; pr = 0; pw = 0; pd = 0; in_txn = 0; stall = 0;
    own = 0; idx = 0; ack_at = 0; to = 0; exp_we = 0; mrd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      dn = {bi.d_done, bi.c_wdone, bi.c_rdone, bi.c_idone};
      if (in_txn && !bi.m_req) begin
        exp_dn = 4'(1 << own);
        chk("r_done", dn, exp_dn);
        chk("r_err", bi.bus_err, to);
        chk("r_busy_len", idx + 1, to ? 4 : ack_at + 1);
        if (own <= 1) chk("r_crdata", bi.c_rdata, to ? 32'hFFFFFFFF : mrd);
        if (own == 3 && !exp_we) chk("r_drdata", bi.d_rdata, to ? 32'hFFFFFFFF : mrd);
        case (own)
          0: begin bi.c_ifetch = 0; pf = 0; end
          1: begin bi.c_rstrobe = 0; pr = 0; end
          2: begin bi.c_wmask = 0; pw = 0; end
          default: begin bi.d_req = 0; pd = 0; end
        endcase
        last_dma_m = (own == 3);
        in_txn = 0;
      end else begin
        chk("r_quiet", {bi.bus_err, dn}, 0);
        if (!in_txn && bi.m_req) begin
          if (pd && (!(pf | pr | pw) || !last_dma_m)) own = 3;
          else if (pw) own = 2;
          else if (pr) own = 1;
          else own = 0;
          case (own)
            0: begin ea = pc_b >> 2; ewe = 0; ewm = 0; eio = 0; end
            1: begin ea = 32'(bi.c_addr); ewe = 0; ewm = 0; eio = bi.c_io; end
            2: begin ea = 32'(bi.c_addr); ewe = 1; ewm = 32'(bi.c_wmask); eio = bi.c_io; end
            default: begin
              ea = 32'(bi.d_addr); ewe = bi.d_we; ewm = bi.d_we ? 32'(bi.d_wmask) : 0; eio = 0;
            end
          endcase
          chk("r_addr", bi.m_addr, ea);
          chk("r_we", bi.m_we, ewe);
          chk("r_wmask", bi.m_wmask, ewm);
          chk("r_io", bi.m_io, eio);
          if (ewe) chk("r_wdata", bi.m_wdata, (own == 2) ? bi.c_wdata : bi.d_wdata);
          exp_we = ewe;
          in_txn = 1; idx = 0;
          to = ($urandom_range(0, 7) == 0);
          ack_at = $urandom_range(0, 3);
          mrd = $urandom; bi.m_rdata = mrd;
        end else if (in_txn) begin
          idx++;
        end
      end
      if (in_txn) bi.m_ack = !to && (idx == ack_at);
      else        bi.m_ack = ($urandom_range(0, 7) == 0);

      if (!in_txn && !bi.m_req && (pf | pr | pw | pd)) stall++;
      else stall = 0;
      if (stall > 2) begin chk("r_grant_wait", stall, 2); stall = 0; end

      if (!pf && $urandom_range(0, 2) == 0) begin
        pc_b = $urandom; bi.c_pc = pc_b[31:1]; bi.c_ifetch = 1; pf = 1;
      end
      if (!pr && $urandom_range(0, 2) == 0) begin
        if (!pw) begin bi.c_addr = 30'($urandom); bi.c_io = 1'($urandom); end
        bi.c_rstrobe = 2'($urandom_range(1, 3)); pr = 1;
      end
      if (!pw && $urandom_range(0, 2) == 0) begin
        if (!pr) begin bi.c_addr = 30'($urandom); bi.c_io = 1'($urandom); end
        bi.c_wdata = $urandom; bi.c_wmask = 4'($urandom_range(1, 15)); pw = 1;
      end
      if (!pd && $urandom_range(0, 2) == 0) begin
        bi.d_addr = 30'($urandom); bi.d_we = 1'($urandom); bi.d_wdata = $urandom;
        bi.d_wmask = 4'($urandom); bi.d_req = 1; pd = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
